// File: rtl/l2_mem_port_arbiter.sv
// Arbiter/sequencer for the shared main-memory port behind the L1 caches.
// Refills become four 32-bit read beats; stores become a single write cycle.
module l2_mem_port_arbiter #(
  parameter int ADDR_W = 19,
  parameter int RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  input  logic              d_rd_req_i,
  input  logic [ADDR_W-1:0] d_rd_addr_i,
  input  logic              d_wr_req_i,
  input  logic [ADDR_W-1:0] d_wr_addr_i,
  input  logic [31:0]       d_wr_data_i,
  input  logic [3:0]        d_wr_strb_i,
  input  logic [31:0]       ram_data_i,
  output logic              ram_read_o,
  output logic [31:0]       ram_read_addr_o,
  output logic [31:0]       ram_write_addr_o,
  output logic [31:0]       ram_data_o,
  output logic [3:0]        wr_strb_o,
  output logic [127:0]      refill_data_o,
  output logic              i_done_o,
  output logic              d_rd_done_o,
  output logic              d_wr_done_o,
  output logic              busy_o
);

  typedef enum logic [2:0] {IDLE, RD_BURST, RD_DRAIN, WR, DONE} state_t;
  typedef enum logic [1:0] {GNT_I, GNT_DRD, GNT_DWR} gnt_t;

  state_t            state_reg, state_next;
  gnt_t              gnt_reg, gnt_next;
  logic              last_data_reg, last_data_next;
  logic [1:0]        issue_cnt_reg, issue_cnt_next;
  logic [1:0]        cap_cnt_reg, cap_cnt_next;
  logic [31:0]       rd_addr_reg, rd_addr_next;
  logic [31:0]       wr_addr_reg, wr_addr_next;
  logic [31:0]       wr_data_reg, wr_data_next;
  logic [3:0]        wr_strb_reg, wr_strb_next;
  logic [RD_LAT-1:0] rd_pipe_reg;
  logic [31:0]       word_reg [4];
  logic              capture;
  logic              data_req;
  logic              unused_addr_bits;

  assign data_req         = d_rd_req_i | d_wr_req_i;
  assign capture          = rd_pipe_reg[RD_LAT-1];
  assign unused_addr_bits = ^{i_addr_i[3:0], d_rd_addr_i[3:0], d_wr_addr_i[1:0]};

  always_comb begin
    state_next     = state_reg;
    gnt_next       = gnt_reg;
    last_data_next = last_data_reg;
    issue_cnt_next = issue_cnt_reg;
    cap_cnt_next   = capture ? cap_cnt_reg + 2'd1 : cap_cnt_reg;
    rd_addr_next   = rd_addr_reg;
    wr_addr_next   = wr_addr_reg;
    wr_data_next   = wr_data_reg;
    wr_strb_next   = wr_strb_reg;
    case (state_reg)
      IDLE: begin
        // INSTR wins a tie only when DATA was granted last.
        if (i_req_i && (!data_req || last_data_reg)) begin
          gnt_next       = GNT_I;
          last_data_next = 1'b0;
          rd_addr_next   = 32'({i_addr_i[ADDR_W-1:4], 4'b0000});
          issue_cnt_next = 2'd0;
          state_next     = RD_BURST;
        end else if (d_wr_req_i) begin
          gnt_next       = GNT_DWR;
          last_data_next = 1'b1;
          wr_addr_next   = 32'({d_wr_addr_i[ADDR_W-1:2], 2'b00});
          wr_data_next   = d_wr_data_i;
          wr_strb_next   = d_wr_strb_i;
          state_next     = WR;
        end else if (d_rd_req_i) begin
          gnt_next       = GNT_DRD;
          last_data_next = 1'b1;
          rd_addr_next   = 32'({d_rd_addr_i[ADDR_W-1:4], 4'b0000});
          issue_cnt_next = 2'd0;
          state_next     = RD_BURST;
        end
      end
      RD_BURST: begin
        issue_cnt_next = issue_cnt_reg + 2'd1;
        if (issue_cnt_reg == 2'd3) state_next = RD_DRAIN;
        else                       rd_addr_next = rd_addr_reg + 32'd4;
      end
      RD_DRAIN: if (capture && cap_cnt_reg == 2'd3) state_next = DONE;
      WR:       state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      gnt_reg       <= GNT_I;
      last_data_reg <= 1'b1;
      issue_cnt_reg <= 2'd0;
      cap_cnt_reg   <= 2'd0;
      rd_addr_reg   <= '0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
      wr_strb_reg   <= '0;
      rd_pipe_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      gnt_reg       <= gnt_next;
      last_data_reg <= last_data_next;
      issue_cnt_reg <= issue_cnt_next;
      cap_cnt_reg   <= cap_cnt_next;
      rd_addr_reg   <= rd_addr_next;
      wr_addr_reg   <= wr_addr_next;
      wr_data_reg   <= wr_data_next;
      wr_strb_reg   <= wr_strb_next;
      // Issue marker delayed by RD_LAT: marks the cycle each beat's data arrives.
      rd_pipe_reg   <= RD_LAT'({rd_pipe_reg, ram_read_o});
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_word
    always_ff @(posedge clk_i) begin
      if (rst_i)                                    word_reg[gi] <= '0;
      else if (capture && cap_cnt_reg == 2'(gi))    word_reg[gi] <= ram_data_i;
    end
  end

  assign ram_read_o       = (state_reg == RD_BURST);
  assign ram_read_addr_o  = rd_addr_reg;
  assign ram_write_addr_o = wr_addr_reg;
  assign ram_data_o       = wr_data_reg;
  assign wr_strb_o        = (state_reg == WR) ? wr_strb_reg : 4'b0000;
  assign refill_data_o    = {word_reg[3], word_reg[2], word_reg[1], word_reg[0]};
  assign i_done_o         = (state_reg == DONE) && (gnt_reg == GNT_I);
  assign d_rd_done_o      = (state_reg == DONE) && (gnt_reg == GNT_DRD);
  assign d_wr_done_o      = (state_reg == DONE) && (gnt_reg == GNT_DWR);
  assign busy_o           = (state_reg != IDLE);

endmodule
